regfile_writeback: RTL and testbench
====================================

// Module: regfile_writeback
// PURPOSE
//  Drives the register file's write port: address_dest, data_dest and write_dest.
//  Merges single-cycle pipeline results with long-latency (load/div) results.
//  Long-latency results are buffered in a small FIFO.
//  Keeps a pending-register scoreboard so decode can stall on outstanding long-latency writes.
//  Sits between the execute/memory stages and the regfile.
// PARAMETERS
//  LL_FIFO_DEPTH  4   long-latency result buffer entries (power of 2, >=2)
// PORTS
//  clk           in   1   clock
//  reset_n       in   1   synchronous active-low reset
//  pipe_valid    in   1   pipeline result valid; always accepted, no backpressure
//  pipe_rd       in   5   pipeline destination register
//  pipe_data     in   32  pipeline result
//  ll_valid      in   1   long-latency result valid
//  ll_ready      out  1   FIFO can accept; transfer when ll_valid & ll_ready
//  ll_rd         in   5   long-latency destination register
//  ll_data       in   32  long-latency result
//  issue_valid   in   1   long-latency op issued; marks issue_rd pending
//  issue_rd      in   5   destination of the issued long-latency op
//  rs1_addr      in   5   decode source 1
//  rs2_addr      in   5   decode source 2
//  rf_rdata1     in   32  regfile read data for rs1_addr (combinational)
//  rf_rdata2     in   32  regfile read data for rs2_addr (combinational)
//  rs1_busy      out  1   rs1 not yet readable; decode must stall
//  rs2_busy      out  1   rs2 not yet readable; decode must stall
//  fwd_rdata1    out  32  operand 1 to decode
//  fwd_rdata2    out  32  operand 2 to decode
//  address_dest  out  5   to regfile
//  data_dest     out  32  to regfile
//  write_dest    out  1   to regfile
//  fifo_count    out  $clog2(LL_FIFO_DEPTH+1)  occupied FIFO entries
// BEHAVIOUR
//  Reset (reset_n=0 at posedge):
//   - write_dest=0, address_dest=0, data_dest=0.
//   - FIFO empty, fifo_count=0, scoreboard pending[31:0]=0.
//   - ll_ready=0 while reset_n=0, including mid-operation; buffered entries are discarded.
//  Write-port outputs are registered: a result selected in cycle N is driven in cycle N+1.
//   The regfile commits it at the end of N+1.
//  Per-cycle selection, strict priority:
//   1. pipe_valid & pipe_rd!=0 -> drive pipe result; FIFO does not pop.
//   2. else FIFO non-empty -> pop head, drive it.
//   3. else write_dest=0; address_dest and data_dest hold their previous values.
//  rd==0 results are dropped on both inputs: ll accepts the handshake but does not enqueue.
//  ll_ready = (fifo_count < LL_FIFO_DEPTH).
//   - No same-cycle pass-through when full.
//   - Push and pop in the same cycle leave the count unchanged.
//   - Pointers wrap modulo LL_FIFO_DEPTH.
//   - FIFO preserves order.
//  Scoreboard:
//   - issue_valid & issue_rd!=0 sets pending[issue_rd].
//   - A FIFO pop for rd clears pending[rd] in the selection cycle.
//   - Same-cycle set and clear of one rd: set wins.
//   - Pipeline writes never clear pending.
//   - Issue to an already-pending rd is illegal (assertion).
//  In-flight write = write_dest & address_dest==rsX & rsX!=0.
//  rsX_busy = pending[rsX] | in-flight write (rs==0 never busy).
//  fwd_rdataX = rf_rdataX.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - Removes the in-flight term from rsX_busy.
//   - On an in-flight write, fwd_rdataX = data_dest.
//   - Saves one stall cycle per back-to-back dependency.
//  Undefined: no bypass mux; behaviour as above.
// STRUCTURE
//  regfile_pkg:
//   - XLEN=32, REG_ADDR_W=5, typedef reg_addr_t.
//   - typedef struct packed {reg_addr_t rd; logic [XLEN-1:0] data;} wb_entry_t.
//  Sub-module wb_fifo: synchronous FIFO of wb_entry_t, DEPTH param, push/pop/full/empty/count.
//  Top holds selection, output registers, scoreboard and bypass/busy logic.
// TESTING
//  1. Reset then idle: write_dest=0, ll_ready=1, fifo_count=0, rs1_busy=0 for every rs1_addr.
//  2. pipe_valid rd=5 data=0xDEADBEEF at N -> write_dest=1, address_dest=5, data_dest=0xDEADBEEF at N+1.
//  3. FIFO holds ll rd=7, and pipe_valid rd=3 in cycles N..N+2:
//     -> x3 written on N+1..N+3; x7 written at N+4; fifo_count 1->0.
//  4. Hold pipe_valid, push 4 ll results:
//     -> ll_ready=0 at count 4; release pipe -> drained in push order; ll_ready returns.
//  5. issue rd=9, poll rs1_addr=9:
//     -> busy until the ll rd=9 result pops.
//     -> Next cycle: busy=1 without bypass, or busy=0 and fwd_rdata1=data with REGFILE_BYPASS_EN.
//  6. rd=0 on pipe and ll, plus reset asserted with FIFO at 3:
//     -> rd=0 results never written; FIFO empty and pending cleared after reset.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file writeback path: register address,
// data width and the buffered long-latency result entry.
package regfile_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    reg_addr_t       rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;

  // x0 is hardwired to zero, so results aimed at it are discarded.
  function automatic logic rd_live(input reg_addr_t rd);
    return rd != '0;
  endfunction
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t for long-latency results; DEPTH must be a
// power of two so the pointers wrap naturally.
import regfile_pkg::*;

module wb_fifo #(
  parameter int  DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_push,
  input  wb_entry_t       i_entry,
  input  logic            i_pop,
  output wb_entry_t       o_head,
  output logic            o_full,
  output logic            o_empty,
  output logic [CW-1:0]   o_count
);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  wb_entry_t     r_mem [DEPTH];
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_entry;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/regfile_writeback.sv
// Regfile write-port arbiter: pipeline results beat buffered long-latency
// results; keeps a pending scoreboard for decode. Option: REGFILE_BYPASS_EN.
import regfile_pkg::*;

module regfile_writeback #(
  parameter int  LL_FIFO_DEPTH = 4,
  localparam int CNT_W         = $clog2(LL_FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_pipe_valid,
  input  logic [REG_ADDR_W-1:0] i_pipe_rd,
  input  logic [XLEN-1:0]       i_pipe_data,
  input  logic                  i_ll_valid,
  output logic                  o_ll_ready,
  input  logic [REG_ADDR_W-1:0] i_ll_rd,
  input  logic [XLEN-1:0]       i_ll_data,
  input  logic                  i_issue_valid,
  input  logic [REG_ADDR_W-1:0] i_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr,
  input  logic [XLEN-1:0]       i_rf_rdata1,
  input  logic [XLEN-1:0]       i_rf_rdata2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic [XLEN-1:0]       o_fwd_rdata1,
  output logic [XLEN-1:0]       o_fwd_rdata2,
  output logic [REG_ADDR_W-1:0] o_address_dest,
  output logic [XLEN-1:0]       o_data_dest,
  output logic                  o_write_dest,
  output logic [CNT_W-1:0]      o_fifo_count
);
  logic                  r_write_dest;
  logic [REG_ADDR_W-1:0] r_address_dest;
  logic [XLEN-1:0]       r_data_dest;
  logic [NUM_REGS-1:0]   r_pending;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_ll_push;
  logic                  w_sel_pipe;
  logic                  w_pop;
  wb_entry_t             w_ll_entry;
  wb_entry_t             w_head;
  logic [NUM_REGS-1:0]   w_set_mask;
  logic [NUM_REGS-1:0]   w_clr_mask;
  logic                  w_inflight1;
  logic                  w_inflight2;

  assign o_ll_ready = reset_n & ~w_full;
  assign w_ll_push  = i_ll_valid & o_ll_ready & rd_live(i_ll_rd);
  assign w_sel_pipe = i_pipe_valid & rd_live(i_pipe_rd);
  assign w_pop      = ~w_sel_pipe & ~w_empty;
  assign w_ll_entry = '{rd: i_ll_rd, data: i_ll_data};

  wb_fifo #(.DEPTH(LL_FIFO_DEPTH)) u_ll_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_ll_push),
    .i_entry (w_ll_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  // Address/data hold their last value on idle cycles; only write_dest drops.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_write_dest   <= 1'b0;
      r_address_dest <= '0;
      r_data_dest    <= '0;
    end else begin
      r_write_dest <= w_sel_pipe | w_pop;
      if (w_sel_pipe) begin
        r_address_dest <= i_pipe_rd;
        r_data_dest    <= i_pipe_data;
      end else if (w_pop) begin
        r_address_dest <= w_head.rd;
        r_data_dest    <= w_head.data;
      end
    end
  end

  always_comb begin
    w_set_mask = '0;
    w_clr_mask = '0;
    if (w_pop) w_clr_mask[w_head.rd] = 1'b1;
    if (i_issue_valid && rd_live(i_issue_rd)) w_set_mask[i_issue_rd] = 1'b1;
  end

  // Set after clear so a same-cycle reissue keeps the register pending.
  always_ff @(posedge clk) begin
    if (!reset_n) r_pending <= '0;
    else          r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
  end

  always_ff @(posedge clk) begin
    if (reset_n && i_issue_valid && rd_live(i_issue_rd))
      assert (!r_pending[i_issue_rd] || w_clr_mask[i_issue_rd]);
  end

  assign w_inflight1 = r_write_dest && (r_address_dest == i_rs1_addr) && rd_live(i_rs1_addr);
  assign w_inflight2 = r_write_dest && (r_address_dest == i_rs2_addr) && rd_live(i_rs2_addr);

`ifdef REGFILE_BYPASS_EN
  assign o_rs1_busy   = r_pending[i_rs1_addr];
  assign o_rs2_busy   = r_pending[i_rs2_addr];
  assign o_fwd_rdata1 = w_inflight1 ? r_data_dest : i_rf_rdata1;
  assign o_fwd_rdata2 = w_inflight2 ? r_data_dest : i_rf_rdata2;
`else
  assign o_rs1_busy   = r_pending[i_rs1_addr] | w_inflight1;
  assign o_rs2_busy   = r_pending[i_rs2_addr] | w_inflight2;
  assign o_fwd_rdata1 = i_rf_rdata1;
  assign o_fwd_rdata2 = i_rf_rdata2;
`endif

  assign o_write_dest   = r_write_dest;
  assign o_address_dest = r_address_dest;
  assign o_data_dest    = r_data_dest;
endmodule

// File: tb/tb_regfile_writeback.sv
// Scoreboard bench for regfile_writeback: a queue-based reference model predicts
// regfile writes; a separate monitor pops and compares each one the DUT drives.
module tb_regfile_writeback;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          pipe_valid = 1'b0, ll_valid = 1'b0, issue_valid = 1'b0;
  logic [4:0]    pipe_rd = '0, ll_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0]   pipe_data = '0, ll_data = '0, rf_rdata1 = '0, rf_rdata2 = '0;
  logic          ll_ready, rs1_busy, rs2_busy, write_dest;
  logic [31:0]   fwd_rdata1, fwd_rdata2, data_dest;
  logic [4:0]    address_dest;
  logic [CW-1:0] fifo_count;

  always #5 clk = ~clk;

  regfile_writeback #(.LL_FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_pipe_valid(pipe_valid), .i_pipe_rd(pipe_rd), .i_pipe_data(pipe_data),
    .i_ll_valid(ll_valid), .o_ll_ready(ll_ready), .i_ll_rd(ll_rd), .i_ll_data(ll_data),
    .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
    .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .o_rs1_busy(rs1_busy), .o_rs2_busy(rs2_busy),
    .o_fwd_rdata1(fwd_rdata1), .o_fwd_rdata2(fwd_rdata2),
    .o_address_dest(address_dest), .o_data_dest(data_dest), .o_write_dest(write_dest),
    .o_fifo_count(fifo_count)
  );

  typedef struct {logic [4:0] rd; logic [31:0] data;} wr_t;

  wr_t        exp_q[$];
  wr_t        ll_q[$];
  bit [31:0]  pend = '0;
  bit         last_v = 1'b0;
  logic [4:0] last_rd = '0;
  logic [31:0] last_data = '0;
  int         errors = 0, checks = 0;
  bit         done = 1'b0;
  logic       rst_at_edge = 1'b0;

  always @(posedge clk) rst_at_edge <= reset_n;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive, check combinational outputs, advance the model.
  task automatic step(input bit rst_n, input bit pv, input logic [4:0] prd, input logic [31:0] pdat,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input bit iv, input logic [4:0] ird, input logic [4:0] a1, input logic [4:0] a2);
    bit  acc, inf1, inf2;
    wr_t w;
    @(negedge clk);
    reset_n = rst_n; pipe_valid = pv; pipe_rd = prd; pipe_data = pdat;
    ll_valid = lv; ll_rd = lrd; ll_data = ldat; issue_valid = iv; issue_rd = ird;
    rs1_addr = a1; rs2_addr = a2; rf_rdata1 = $urandom; rf_rdata2 = $urandom;
    #1;
    chk("ll_ready", ll_ready, 32'(rst_n && ll_q.size() < DEPTH));
    chk("fifo_count", fifo_count, ll_q.size());
    inf1 = last_v && last_rd == a1 && a1 != 0;
    inf2 = last_v && last_rd == a2 && a2 != 0;
    chk("rs1_busy", rs1_busy, 32'(a1 != 0 && (pend[a1] || (!BYPASS && inf1))));
    chk("rs2_busy", rs2_busy, 32'(a2 != 0 && (pend[a2] || (!BYPASS && inf2))));
    chk("fwd_rdata1", fwd_rdata1, (BYPASS && inf1) ? last_data : rf_rdata1);
    chk("fwd_rdata2", fwd_rdata2, (BYPASS && inf2) ? last_data : rf_rdata2);
    if (!rst_n) begin
      ll_q.delete(); pend = '0; last_v = 1'b0; last_rd = '0; last_data = '0;
    end else begin
      acc = lv && ll_q.size() < DEPTH;
      last_v = 1'b0;
      if (pv && prd != 0) begin
        w.rd = prd; w.data = pdat;
        exp_q.push_back(w);
        last_v = 1'b1; last_rd = prd; last_data = pdat;
      end else if (ll_q.size() != 0) begin
        w = ll_q.pop_front();
        exp_q.push_back(w);
        pend[w.rd] = 1'b0;
        last_v = 1'b1; last_rd = w.rd; last_data = w.data;
      end
      if (acc && lrd != 0) begin
        w.rd = lrd; w.data = ldat;
        ll_q.push_back(w);
      end
      if (iv && ird != 0) pend[ird] = 1'b1;
    end
  endtask

  task automatic idle(input int n, input logic [4:0] a1);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, a1, 0);
  endtask

  // Monitor: every driven write must match the oldest predicted write.
  initial begin
    wr_t         w;
    logic [4:0]  pa;
    logic [31:0] pd;
    pa = '0; pd = '0;
    forever begin
      @(negedge clk); #2;
      if (done) break;
      if (!rst_at_edge) begin
        chk("reset_write_dest", write_dest, 0);
        chk("reset_address_dest", address_dest, 0);
        chk("reset_data_dest", data_dest, 0);
        pa = '0; pd = '0;
      end else if (write_dest === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", address_dest, data_dest);
        end else begin
          w = exp_q.pop_front();
          chk("wr_address", address_dest, w.rd);
          chk("wr_data", data_dest, w.data);
        end
        pa = address_dest; pd = data_dest;
      end else begin
        chk("idle_write_dest", write_dest, 0);
        chk("idle_hold_address", address_dest, pa);
        chk("idle_hold_data", data_dest, pd);
      end
    end
  end

  initial begin
    logic [4:0] ird, last_iss;
    bit         iv;
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Idle after reset: nothing busy for any source register.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));
    // Single pipeline write.
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
    idle(2, 5);
    // Pipeline has priority over a buffered long-latency result.
    step(1, 0, 0, 0, 1, 7, 32'h7777_0007, 0, 0, 7, 3);
    step(1, 1, 3, 32'h3333_0001, 0, 0, 0, 0, 0, 7, 3);
    step(1, 1, 3, 32'h3333_0002, 0, 0, 0, 0, 0, 7, 3);
    step(1, 1, 3, 32'h3333_0003, 0, 0, 0, 0, 0, 7, 3);
    idle(3, 7);
    // Fill the FIFO behind a held pipeline, then drain in order.
    for (int k = 0; k < 6; k++)
      step(1, 1, 5'(1 + k), $urandom, 1, 5'(10 + k), 32'hA000_0000 + 32'(k), 0, 0, 5'(10 + k), 0);
    idle(6, 10);
    // Scoreboard: rd=9 busy until its long-latency result pops.
    step(1, 0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    idle(3, 9);
    step(1, 0, 0, 0, 1, 9, 32'h9999_9999, 0, 0, 9, 9);
    idle(4, 9);
    // rd=0 drops, then reset with three buffered entries.
    step(1, 1, 0, 32'h0BAD_0000, 1, 0, 32'h0BAD_0001, 0, 0, 0, 0);
    idle(2, 0);
    step(1, 1, 1, 32'h1, 1, 20, 32'h20, 1, 20, 20, 21);
    step(1, 1, 1, 32'h2, 1, 21, 32'h21, 1, 21, 20, 21);
    step(1, 1, 1, 32'h3, 1, 22, 32'h22, 0, 0, 20, 21);
    step(0, 1, 1, 32'h4, 1, 23, 32'h23, 0, 0, 20, 21);
    idle(3, 20);
    // Randomized traffic.
    last_iss = 5'd1;
    for (int n = 0; n < 2500; n++) begin
      ird = 5'($urandom_range(0, 31));
      iv  = ($urandom_range(0, 4) == 0) && !pend[ird];
      if (iv && ird != 0) last_iss = ird;
      step(($urandom_range(0, 299) != 0),
           ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom,
           iv, ird,
           ($urandom_range(0, 1) == 1) ? last_iss : 5'($urandom_range(0, 31)),
           ($urandom_range(0, 3) == 0) ? last_rd : 5'($urandom_range(0, 31)));
    end
    idle(8, 0);
    done = 1'b1;
    @(negedge clk); #5;
    chk("exp_queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
